// File: rtl/spi_ram_pkg.sv
// Shared command codes and FSM state encoding for the SPI RAM command sequencer.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/spi_ram_ctrl.sv
// Command sequencer between the SPI slave and a negedge-write register file.
// Define SPI_RAM_ADDR_AUTO_INC_EN to post-increment addresses after each write/read.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_SIZE = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_rx_valid,
    input  logic [DATA_WIDTH+1:0]   i_rx_data,
    output logic [ADDRESS_SIZE-1:0] o_mem_address,
    output logic [DATA_WIDTH-1:0]   o_mem_data,
    output logic                    o_mem_wr_en,
    input  logic [DATA_WIDTH-1:0]   i_mem_data,
    output logic [DATA_WIDTH-1:0]   o_tx_data,
    output logic                    o_tx_valid,
    output logic                    o_busy,
    output logic                    o_err
);

    state_t                  state;
    logic [ADDRESS_SIZE-1:0] wr_addr_q;
    logic [ADDRESS_SIZE-1:0] rd_addr_q;
    logic                    rd_addr_vld;

    logic [1:0]              cmd;
    logic [DATA_WIDTH-1:0]   payload;
    logic [ADDRESS_SIZE-1:0] addr_in;

    assign cmd     = i_rx_data[DATA_WIDTH+1:DATA_WIDTH];
    assign payload = i_rx_data[DATA_WIDTH-1:0];
    assign addr_in = payload[ADDRESS_SIZE-1:0];

`ifdef SPI_RAM_ADDR_AUTO_INC_EN
    logic [ADDRESS_SIZE-1:0] wr_addr_next;
    logic [ADDRESS_SIZE-1:0] rd_addr_next;

    // Natural overflow of the address width gives the max -> 0 wrap.
    assign wr_addr_next = wr_addr_q + 1'b1;
    assign rd_addr_next = rd_addr_q + 1'b1;
`endif

    // o_mem_data doubles as the write-data register; it is only consumed while wr_en is high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            rd_addr_vld   <= 1'b0;
            o_mem_address <= '0;
            o_mem_data    <= '0;
            o_mem_wr_en   <= 1'b0;
            o_tx_data     <= '0;
            o_tx_valid    <= 1'b0;
            o_busy        <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_rx_valid) begin
                        case (cmd)
                            CMD_WR_ADDR: begin
                                wr_addr_q     <= addr_in;
                                o_mem_address <= addr_in;
                            end
                            CMD_WR_DATA: begin
                                o_mem_data  <= payload;
                                o_mem_wr_en <= 1'b1;
                                o_busy      <= 1'b1;
                                state       <= ST_WRITE;
                            end
                            CMD_RD_ADDR: begin
                                rd_addr_q   <= addr_in;
                                rd_addr_vld <= 1'b1;
                            end
                            default: begin
                                if (rd_addr_vld) begin
                                    o_mem_address <= rd_addr_q;
                                    o_busy        <= 1'b1;
                                    state         <= ST_READ;
                                end else begin
                                    o_err <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                ST_WRITE: begin
                    o_mem_wr_en <= 1'b0;
                    o_busy      <= 1'b0;
                    state       <= ST_IDLE;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
                    wr_addr_q     <= wr_addr_next;
                    o_mem_address <= wr_addr_next;
`endif
                end
                ST_READ: begin
                    o_tx_data     <= i_mem_data;
                    o_tx_valid    <= 1'b1;
                    o_mem_address <= wr_addr_q;
                    state         <= ST_RESP;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
                    rd_addr_q <= rd_addr_next;
`endif
                end
                ST_RESP: begin
                    o_tx_valid <= 1'b0;
                    o_busy     <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            // Frames arriving mid-operation are dropped and flagged.
            if (state != ST_IDLE && i_rx_valid)
                o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl with a negedge-write register file model and a read-data scoreboard.
module tb_spi_ram_ctrl;
    import spi_ram_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_rx_valid;
    logic [9:0] i_rx_data;
    logic [7:0] o_mem_address;
    logic [7:0] o_mem_data;
    logic       o_mem_wr_en;
    logic [7:0] i_mem_data;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       o_busy;
    logic       o_err;

    bit   [7:0] mem [256];
    logic [7:0] sb [$];
    int total = 0;
    int bad = 0;
    int wr_count = 0;
    int tx_count = 0;
    int wr_before;

    spi_ram_ctrl #(.DATA_WIDTH(8), .ADDRESS_SIZE(8)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_rx_valid    (i_rx_valid),
        .i_rx_data     (i_rx_data),
        .o_mem_address (o_mem_address),
        .o_mem_data    (o_mem_data),
        .o_mem_wr_en   (o_mem_wr_en),
        .i_mem_data    (i_mem_data),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    always #5 i_clk = ~i_clk;

    // Register file: combinational read, write sampled on the falling edge.
    assign i_mem_data = mem[o_mem_address];
    always @(negedge i_clk) if (o_mem_wr_en) mem[o_mem_address] <= o_mem_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every tx strobe must match the oldest expected read.
    always @(negedge i_clk) begin
        if (o_mem_wr_en) wr_count++;
        if (o_tx_valid) begin
            tx_count++;
            if (sb.size() == 0) check("tx_unexpected", {31'd0, o_tx_valid}, 32'd0);
            else check("tx_data", {24'd0, o_tx_data}, {24'd0, sb.pop_front()});
        end
    end

    task automatic send(input logic [1:0] c, input logic [7:0] p);
        i_rx_valid = 1'b1;
        i_rx_data  = {c, p};
        @(posedge i_clk); #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, {24'd0, o_mem_address}, 32'd0);
        check({tag, "_data"}, {24'd0, o_mem_data}, 32'd0);
        check({tag, "_ctl"}, {27'd0, o_mem_wr_en, o_tx_valid, o_busy, o_err, 1'b0}, 32'd0);
        check({tag, "_tx"}, {24'd0, o_tx_data}, 32'd0);
    endtask

    initial begin
        i_rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = '0;
        idle(2);
        check_all_zero("reset");
        i_rst = 1'b0;
        idle(1);

        // Read with no address latched since reset
        send(CMD_RD_DATA, 8'h00);
        check("noaddr_err", {31'd0, o_err}, 32'd1);
        check("noaddr_busy", {31'd0, o_busy}, 32'd0);
        idle(1);
        check("noaddr_err_clr", {31'd0, o_err}, 32'd0);

        // Write then read back
        send(CMD_WR_ADDR, 8'h12);
        check("wa_addr", {24'd0, o_mem_address}, 32'h12);
        wr_before = wr_count;
        send(CMD_WR_DATA, 8'hA5);
        check("wr_en", {30'd0, o_mem_wr_en, o_busy}, 32'd3);
        check("wr_addr", {24'd0, o_mem_address}, 32'h12);
        check("wr_data", {24'd0, o_mem_data}, 32'hA5);
        idle(1);
        check("wr_en_clr", {30'd0, o_mem_wr_en, o_busy}, 32'd0);
        check("wr_pulses", wr_count - wr_before, 32'd1);
        check("mem_12", {24'd0, mem[8'h12]}, 32'hA5);
        send(CMD_RD_ADDR, 8'h12);
        sb.push_back(8'hA5);
        send(CMD_RD_DATA, 8'h00);
        check("rd_state", {30'd0, o_busy, o_tx_valid}, 32'd2);
        check("rd_addr", {24'd0, o_mem_address}, 32'h12);
        idle(1);
        check("rd_valid_k2", {31'd0, o_tx_valid}, 32'd1);
        check("rd_txdata", {24'd0, o_tx_data}, 32'hA5);
        idle(1);
        check("rd_valid_clr", {30'd0, o_tx_valid, o_busy}, 32'd0);
        check("rd_txdata_hold", {24'd0, o_tx_data}, 32'hA5);

        // Repeat read: address either held or post-incremented
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
        sb.push_back(8'h00);
`else
        sb.push_back(8'hA5);
`endif
        send(CMD_RD_DATA, 8'h00);
        idle(3);

        // Overrun: second frame lands while in WRITE
        send(CMD_WR_ADDR, 8'h40);
        wr_before = wr_count;
        send(CMD_WR_DATA, 8'h3C);
        send(CMD_WR_DATA, 8'h77);
        check("ovr_err", {31'd0, o_err}, 32'd1);
        check("ovr_busy", {31'd0, o_busy}, 32'd0);
        idle(1);
        check("ovr_err_clr", {31'd0, o_err}, 32'd0);
        check("ovr_pulses", wr_count - wr_before, 32'd1);
        check("ovr_mem40", {24'd0, mem[8'h40]}, 32'h3C);
        check("ovr_mem41", {24'd0, mem[8'h41]}, 32'h00);

        // Address wrap-around
        send(CMD_WR_ADDR, 8'hFF);
        send(CMD_WR_DATA, 8'h11);
        idle(1);
        send(CMD_WR_DATA, 8'h22);
        idle(1);
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
        check("wrap_memFF", {24'd0, mem[8'hFF]}, 32'h11);
        check("wrap_mem00", {24'd0, mem[8'h00]}, 32'h22);
`else
        check("wrap_memFF", {24'd0, mem[8'hFF]}, 32'h22);
        check("wrap_mem00", {24'd0, mem[8'h00]}, 32'h00);
`endif

        // Reset during READ: outputs clear asynchronously, no tx strobe follows
        send(CMD_RD_ADDR, 8'h40);
        send(CMD_RD_DATA, 8'h00);
        check("rstrd_busy", {31'd0, o_busy}, 32'd1);
        check("rstrd_addr", {24'd0, o_mem_address}, 32'h40);
        i_rst = 1'b1;
        #1;
        check_all_zero("rstrd");
        idle(3);
        i_rst = 1'b0;
        idle(2);
        check("rstrd_idle", {30'd0, o_busy, o_tx_valid}, 32'd0);
        send(CMD_RD_DATA, 8'h00);
        check("rstrd_vld_clr", {31'd0, o_err}, 32'd1);
        idle(2);

        check("sb_empty", sb.size(), 32'd0);
        check("tx_count", tx_count, 32'd2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
